keypad_bcd_encoder: RTL



---
 rtl/keypad_pkg.sv | 23 ++
 rtl/prio_enc10.sv | 33 +++
 rtl/keypad_bcd_encoder.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/keypad_pkg.sv
`default_nettype none
// ============================================================================
// Module      : keypad_pkg
// Description : Shared types and constants for the keypad BCD encoder and
//               its 10-to-4 priority encoder.
//               Contents: state_t (controller states), c_bcd_w (code width),
//               c_key_count (number of decimal key lines).
// Revision    : 1.0 - initial release
// ============================================================================
package keypad_pkg;

  localparam int c_bcd_w     = 4;
  localparam int c_key_count = 10;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETTLE  = 2'd1,
    OFFER   = 2'd2,
    RELEASE = 2'd3
  } state_t;

endpackage : keypad_pkg
`default_nettype wire

// File: rtl/prio_enc10.sv
`default_nettype none
// ============================================================================
// Module      : prio_enc10
// Description : Combinational 10-line to 4-bit highest-index priority
//               encoder with an any-line-set flag.
//   i_keys  in  10  key lines, bit 9 has the highest priority
//   o_code  out  4  index of the highest set line (0 when none set)
//   o_any   out  1  1 when any key line is set
// Revision    : 1.0 - initial release
// ============================================================================
module prio_enc10
  import keypad_pkg::*;
(
  input  logic [c_key_count-1:0] i_keys,
  output logic [c_bcd_w-1:0]     o_code,
  output logic                   o_any
);

  // Ascending scan: later (higher) indices overwrite lower ones, so the
  // surviving value is the highest set line.
  always_comb begin
    o_code = '0;
    for (int i = 0; i < c_key_count; i++) begin
      if (i_keys[i]) begin
        o_code = c_bcd_w'(i);
      end
    end
  end

  assign o_any = |i_keys;

endmodule : prio_enc10
`default_nettype wire

// File: rtl/keypad_bcd_encoder.sv
`default_nettype none
// ============================================================================
// Module      : keypad_bcd_encoder
// Description : Synchronizes and debounces ten decimal key lines, priority
//               encodes them (I9 highest) and offers one BCD code per key
//               press through a STB/ACK handshake. No auto-repeat.
//   CLK   in   1  system clock, rising edge
//   RST   in   1  asynchronous active-high reset
//   I     in  10  key lines, asynchronous to CLK
//   ACK   in   1  consumer accepts the code when STB=1
//   A..D  out  1  BCD code bits (A = LSB, D = MSB), hold last delivered code
//   STB   out  1  code valid on A..D
//   GS    out  1  registered "any synchronized key line high"
// Revision    : 1.0 - initial release
// ============================================================================
module keypad_bcd_encoder
  import keypad_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic [c_key_count-1:0] I,
  input  logic                   ACK,
  output logic                   A,
  output logic                   B,
  output logic                   C,
  output logic                   D,
  output logic                   STB,
  output logic                   GS
);

  localparam int              c_cnt_w   = $clog2(DEBOUNCE_CYCLES);
  localparam logic [c_cnt_w-1:0] c_cnt_max = c_cnt_w'(DEBOUNCE_CYCLES - 1);

  logic [c_key_count-1:0] r_sync1;
  logic [c_key_count-1:0] r_sync2;
  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [c_cnt_w-1:0]     r_cnt;
  logic [c_cnt_w-1:0]     w_cnt_nxt;
  logic [c_bcd_w-1:0]     r_key;
  logic [c_bcd_w-1:0]     w_key_nxt;
  logic [c_bcd_w-1:0]     r_code;
  logic [c_bcd_w-1:0]     w_code_nxt;
  logic                   r_stb;
  logic                   w_stb_nxt;
  logic                   r_gs;
  logic [c_bcd_w-1:0]     w_prio;
  logic                   w_any;

  prio_enc10 u_prio (
    .i_keys (r_sync2),
    .o_code (w_prio),
    .o_any  (w_any)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_state <= IDLE;
      r_cnt   <= '0;
      r_key   <= '0;
      r_code  <= '0;
      r_stb   <= 1'b0;
      r_gs    <= 1'b0;
    end else begin
      r_sync1 <= I;
      r_sync2 <= r_sync1;
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_key   <= w_key_nxt;
      r_code  <= w_code_nxt;
      r_stb   <= w_stb_nxt;
      r_gs    <= w_any;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_key_nxt   = r_key;
    w_code_nxt  = r_code;
    w_stb_nxt   = r_stb;
    case (r_state)
      IDLE: begin
        if (w_any) begin
          w_state_nxt = SETTLE;
          w_key_nxt   = w_prio;
          w_cnt_nxt   = '0;
        end
      end
      SETTLE: begin
        if (!w_any) begin
          w_state_nxt = IDLE;
        end else if (w_prio != r_key) begin
          // A different key won priority: restart the stability window.
          w_key_nxt = w_prio;
          w_cnt_nxt = '0;
        end else if (r_cnt == c_cnt_max) begin
          w_state_nxt = OFFER;
          w_code_nxt  = r_key;
          w_stb_nxt   = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      OFFER: begin
        // Code and strobe are frozen here; key activity is ignored.
        if (ACK) begin
          w_state_nxt = RELEASE;
          w_stb_nxt   = 1'b0;
          w_cnt_nxt   = '0;
        end
      end
      RELEASE: begin
        // Any key activity restarts the release window, so a new press
        // made before a full release is never reported.
        if (w_any) begin
          w_cnt_nxt = '0;
        end else if (r_cnt == c_cnt_max) begin
          w_state_nxt = IDLE;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_stb_nxt   = 1'b0;
      end
    endcase
  end

  assign {D, C, B, A} = r_code;
  assign STB          = r_stb;
  assign GS           = r_gs;

endmodule : keypad_bcd_encoder
`default_nettype wire
